shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares a single 32-bit barrel shifter between two requesters, such as the integer ALU issue port and the address/extract unit. It arbitrates round-robin between them and sequences one shift per accepted request: logical right, logical left, or optionally arithmetic right. Each result is registered in a one-entry output buffer with a valid/ready handshake and tagged with the requester ID. The shifter datapath is the existing log-stage mux chain (stages 1/2/4/8/16), instantiated once inside this block.

## Interface

- WIDTH, 32: operand/result width; only 32 is supported.
- SHW, 5: shift-amount width, equal to log2(WIDTH).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand.
- req0_b  in  SHW  requester 0 shift amount.
- req0_op  in  2  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  out  1  output buffer holds a result.
- rsp_ready  in  1  consumer takes the result.
- rsp_c  out  WIDTH  shift result.
- rsp_id  out  1  requester that issued the result.

## Operation

- Opcodes:
  - 00: SRL (zero fill).
  - 01: SLL (zero fill).
  - 10: SRA (see Configuration).
  - 11: reserved; result = a unchanged.
- Shift amount b is taken modulo 32 by construction. b=0 returns a for every opcode.
- SLL is implemented by bit-reversing a, running SRL, and bit-reversing the result. No second shifter is instantiated.
- Two states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- accept = (state==EMPTY) or (state==FULL and rsp_ready).
- Arbitration, evaluated combinationally each cycle:
  - Only one request valid: grant it.
  - Both valid: grant the requester not granted last (last_gnt pointer).
  - No request valid: no grant.
- reqN_ready = accept and grant==N. At most one ready is high per cycle.
- A handshake occurs when valid and ready are both high. On that edge:
  - rsp_c and rsp_id load from the shifter output and grant ID.
  - state -> FULL.
  - last_gnt <= granted ID.
- FULL with rsp_ready=1 and no new handshake -> EMPTY. rsp_c and rsp_id hold their stale values.
- FULL with rsp_ready=0 -> hold. No req*_ready is asserted and rsp_c, rsp_id, rsp_valid are stable.
- Requester inputs are sampled only on the handshake edge. Requesters must hold valid and operands stable until ready.
- last_gnt changes only on a handshake. An idle cycle does not rotate priority.

## Timing

- Reset values:
  - rsp_valid=0.
  - rsp_c=0.
  - rsp_id=0.
  - last_gnt=1, so requester 0 wins the first contested cycle.
  - req0_ready and req1_ready follow the combinational rule, so both are 0 during reset because accept is gated by rst.
- Latency: a request accepted at edge T gives rsp_valid=1 after edge T (1 cycle).
- Throughput: 1 result/cycle when rsp_ready is held high (back-to-back drain and fill in the same cycle).
- ready depends combinationally on rsp_ready and on both valids. valid outputs never depend on ready inputs.
- Reset asserted mid-operation: the buffered result is dropped immediately (rsp_valid=0). No handshake completes while rst=1.
- The shifter path is one cycle of combinational logic: 5 mux levels plus the reversal muxes.

## Configuration

- SHIFT_ARB_SRA_EN defined:
  - opcode 10 performs an arithmetic right shift; vacated bits are filled with a[31].
  - Implemented by feeding a fill bit into each shift stage.
- Not defined:
  - opcode 10 behaves exactly as SRL.
  - The fill logic is not synthesized.

## Test plan

- Reset, then req0 with a=0x8000_00F0, b=4, op=00 -> req0_ready=1 that cycle. Next cycle rsp_valid=1, rsp_c=0x0800_000F, rsp_id=0.
- Both requesters valid for 4 cycles, rsp_ready=1: req0 a=0x1, b=1, op=01; req1 a=0x10, b=4, op=00 -> grants alternate 0,1,0,1. Results alternate 0x2 (id 0) and 0x1 (id 1), one per cycle.
- rsp_ready=0 with the buffer FULL for 3 cycles while req1 is valid -> req1_ready=0 and rsp_c stable. Raising rsp_ready drains and accepts req1 in the same cycle.
- op=10, a=0x8000_0000, b=31 -> rsp_c=0xFFFF_FFFF when SHIFT_ARB_SRA_EN is defined, 0x0000_0001 when it is not. op=11 with b=7 returns a unchanged.
- Assert rst while FULL -> rsp_valid=0 and rsp_c=0 asynchronously. After release, the first contested cycle grants req0.
- b=0 for op=00/01/10 with a=0xDEAD_BEEF -> rsp_c=0xDEAD_BEEF.

Source files
------------

// File: rtl/shift_arbiter.sv
// Shared 32-bit barrel shifter for two requesters, round-robin arbitrated, with a one-entry result buffer.
// Latency: a request accepted at edge T shows rsp_valid=1 after edge T. Sustains one result per cycle.
// Backpressure: while the buffer is full and rsp_ready=0, neither requester is accepted.
// Optional macro SHIFT_ARB_SRA_EN: opcode 10 is an arithmetic right shift. Without it, opcode 10 acts as SRL.
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [SHW-1:0]   req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [SHW-1:0]   req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_id
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  logic [0:0]       state;
  logic             last_gnt;
  logic             any_req;
  logic             gnt_id;
  logic             accept;
  logic             handshake;
  logic [WIDTH-1:0] sel_a;
  logic [SHW-1:0]   sel_b;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] shin;
  logic [WIDTH-1:0] shout;
  logic [WIDTH-1:0] result;

  // Mirror bit order so the single right-shifter can also produce left shifts.
  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  assign rsp_valid = (state == FULL);

  // Round-robin grant: a lone requester always wins; a contested cycle goes to the one not served last.
  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_gnt;
    end else begin
      gnt_id = req1_valid;
    end
  end

  // The buffer can take a new result when empty or when it is being drained this cycle; never in reset.
  always_comb begin
    accept     = ~rst & ((state == EMPTY) | rsp_ready);
    handshake  = accept & any_req;
    req0_ready = handshake & ~gnt_id;
    req1_ready = handshake &  gnt_id;
  end

  // Steer the granted requester's operands into the shared datapath.
  always_comb begin
    if (gnt_id) begin
      sel_a  = req1_a;
      sel_b  = req1_b;
      sel_op = req1_op;
    end else begin
      sel_a  = req0_a;
      sel_b  = req0_b;
      sel_op = req0_op;
    end
  end

`ifdef SHIFT_ARB_SRA_EN
  logic fill;
  assign fill = (sel_op == OP_SRA) & sel_a[WIDTH-1];
`endif

  // Log-stage right-shift mux chain (1/2/4/8/16); left shifts enter and leave bit-reversed.
  always_comb begin
    shin  = (sel_op == OP_SLL) ? bit_rev(sel_a) : sel_a;
    shout = shin;
    for (int k = 0; k < SHW; k++) begin
      if (sel_b[k]) begin
`ifdef SHIFT_ARB_SRA_EN
        shout = (shout >> (1 << k)) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> (1 << k)));
`else
        shout = shout >> (1 << k);
`endif
      end
    end
  end

  // Final result select: undo the reversal for SLL, pass the operand through for the reserved opcode.
  always_comb begin
    case (sel_op)
      OP_SLL:  result = bit_rev(shout);
      OP_NOP:  result = sel_a;
      default: result = shout;
    endcase
  end

  // Output buffer and priority pointer; a fill may coincide with a drain for full throughput.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      rsp_c    <= '0;
      rsp_id   <= 1'b0;
      last_gnt <= 1'b1;
    end else if (handshake) begin
      state    <= FULL;
      rsp_c    <= result;
      rsp_id   <= gnt_id;
      last_gnt <= gnt_id;
    end else if (state == FULL && rsp_ready) begin
      state    <= EMPTY;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed vectors with literal expectations plus a per-cycle reference model.
module tb_shift_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [4:0]  req0_b;
  logic [1:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [4:0]  req1_b;
  logic [1:0]  req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_c;
  logic        rsp_id;

  int checks = 0;
  int errors = 0;

  shift_arbiter #(.WIDTH(32), .SHW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_c      (rsp_c),
    .rsp_id     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shift from plain arithmetic.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] b, input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'd0: r = a >> b;
      2'd1: r = a << b;
`ifdef SHIFT_ARB_SRA_EN
      2'd2: r = $signed(a) >>> b;
`else
      2'd2: r = a >> b;
`endif
      default: r = a;
    endcase
    return r;
  endfunction

  // Model state: buffer occupancy, contents, and who was served last.
  logic        m_full = 1'b0;
  logic [31:0] m_c    = '0;
  logic        m_id   = 1'b0;
  logic        m_last = 1'b1;

  // Per-cycle compare at the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    int gnt;
    logic can_take;
    if (rst) begin
      m_full = 1'b0;
      m_c    = '0;
      m_id   = 1'b0;
      m_last = 1'b1;
      chk("m_rst_rdy0", req0_ready, 0);
      chk("m_rst_rdy1", req1_ready, 0);
      chk("m_rst_vld", rsp_valid, 0);
      chk("m_rst_c", rsp_c, 0);
      chk("m_rst_id", rsp_id, 0);
    end else begin
      if (req0_valid && req1_valid) gnt = m_last ? 0 : 1;
      else if (req0_valid)          gnt = 0;
      else if (req1_valid)          gnt = 1;
      else                          gnt = -1;
      can_take = !m_full || rsp_ready;
      chk("m_rdy0", req0_ready, (can_take && gnt == 0) ? 1 : 0);
      chk("m_rdy1", req1_ready, (can_take && gnt == 1) ? 1 : 0);
      chk("m_vld", rsp_valid, m_full);
      if (m_full) begin
        chk("m_c", rsp_c, m_c);
        chk("m_id", rsp_id, m_id);
      end
      if (can_take && gnt == 0) begin
        m_c = ref_shift(req0_a, req0_b, req0_op); m_id = 1'b0; m_full = 1'b1; m_last = 1'b0;
      end else if (can_take && gnt == 1) begin
        m_c = ref_shift(req1_a, req1_b, req1_op); m_id = 1'b1; m_full = 1'b1; m_last = 1'b1;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sra_exp;

  initial begin
`ifdef SHIFT_ARB_SRA_EN
    sra_exp = 32'hFFFF_FFFF;
`else
    sra_exp = 32'h0000_0001;
`endif
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h8000_00F0; req0_b = 5'd4; req0_op = 2'd0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'd0;
    rsp_ready = 1'b1;

    // Reset values; ready gated off even with a valid request.
    @(negedge clk);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_c", rsp_c, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_rdy0", req0_ready, 0);

    // Single SRL from requester 0.
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("srl_rdy0", req0_ready, 1);
    chk("srl_rdy1", req1_ready, 0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_b = 5'd7; req1_op = 2'd3;
    @(negedge clk);
    chk("srl_vld", rsp_valid, 1);
    chk("srl_c", rsp_c, 32'h0800_000F);
    chk("srl_id", rsp_id, 0);
    chk("nop_rdy1", req1_ready, 1);

    // Contested stream: grants alternate 0,1,0,1.
    cyc();
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 5'd1; req0_op = 2'd1;
    req1_valid = 1'b1; req1_a = 32'h10; req1_b = 5'd4; req1_op = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      if (i == 0) begin
        chk("nop_c", rsp_c, 32'h1234_5678);
        chk("nop_id", rsp_id, 1);
      end else begin
        chk("rr_c", rsp_c, (i % 2 == 1) ? 32'h2 : 32'h1);
        chk("rr_id", rsp_id, (i % 2 == 1) ? 0 : 1);
      end
      chk("rr_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_rdy1", req1_ready, (i % 2 == 1) ? 1 : 0);
    end

    // Backpressure: buffer full, consumer stalled, req1 waiting with an SRA.
    cyc();
    rsp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_a = 32'h8000_0000; req1_b = 5'd31; req1_op = 2'd2;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) cyc();
      @(negedge clk);
      chk("bp_rdy1", req1_ready, 0);
      chk("bp_vld", rsp_valid, 1);
      chk("bp_c", rsp_c, 32'h1);
      chk("bp_id", rsp_id, 1);
    end
    cyc(); rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy1", req1_ready, 1);
    cyc(); req1_valid = 1'b0;
    @(negedge clk);
    chk("sra_c", rsp_c, sra_exp);
    chk("sra_id", rsp_id, 1);

    // Zero shift amount returns the operand for SRL/SLL/SRA.
    cyc();
    req0_valid = 1'b1; req0_a = 32'hDEAD_BEEF; req0_b = 5'd0;
    for (int k = 0; k < 3; k++) begin
      req0_op = k[1:0];
      @(negedge clk);
      chk("b0_rdy0", req0_ready, 1);
      if (k > 0) chk("b0_c", rsp_c, 32'hDEAD_BEEF);
      cyc();
    end
    req0_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    chk("b0_last_c", rsp_c, 32'hDEAD_BEEF);
    chk("b0_last_vld", rsp_valid, 1);

    // Asynchronous reset while full, then first contested cycle favours requester 0.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_vld", rsp_valid, 0);
    chk("arst_c", rsp_c, 0);
    cyc();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy0", req0_ready, 1);
    chk("post_rst_rdy1", req1_ready, 0);
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_id", rsp_id, 0);
    chk("post_rst_c", rsp_c, 32'hDEAD_BEEF);
    cyc(); cyc();
    @(negedge clk);
    chk("drain_vld", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
